// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed register memory.
// Every access phase lasts WAIT_CYCLES+1 cycles. Misaligned or out-of-range
// addresses complete with PSLVERR=1 and leave the memory untouched.
module apb_slave_mem #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int unsigned IdxW  = ADDR_WIDTH - 2;
  localparam int unsigned MemAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  write_q, write_d;
  logic [MemAw-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  setup;
  logic [IdxW-1:0]       setup_idx;
  logic [MemAw-1:0]      setup_mem_idx;
  logic                  setup_err;
  logic                  mem_we;

  // A setup edge restarts the transfer regardless of the current state.
  assign setup         = PSEL & ~PENABLE;
  assign setup_idx     = PADDR[ADDR_WIDTH-1:2];
  assign setup_mem_idx = setup_idx[MemAw-1:0];
  assign setup_err     = (PADDR[1:0] != 2'b00) || (32'(setup_idx) >= DEPTH);

  // State register and registered outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      write_q   <= write_d;
      idx_q     <= idx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (setup) begin
      state_d = (WAIT_CYCLES == 0) ? StDone : StWait;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StWait: begin
          if (!PSEL) begin
            state_d = StIdle;
          end else if (cnt_q <= 4'd1) begin
            state_d = StDone;
          end
        end
        // Either the completing edge or an abort; both end the transfer.
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output, counter and memory-write-enable logic.
  always_comb begin
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    write_d   = write_q;
    idx_d     = idx_q;
    mem_we    = 1'b0;
    if (setup) begin
      write_d   = PWRITE;
      idx_d     = setup_mem_idx;
      pslverr_d = setup_err;
      prdata_d  = (!PWRITE && !setup_err) ? mem_q[setup_mem_idx] : '0;
      cnt_d     = 4'(WAIT_CYCLES);
      pready_d  = (WAIT_CYCLES == 0);
    end else begin
      unique case (state_q)
        StIdle: ;
        StWait: begin
          if (!PSEL) begin
            cnt_d     = '0;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
          end else if (PENABLE) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
              pready_d = 1'b1;
            end
          end
        end
        StDone: begin
          // PSEL=1 here implies PENABLE=1, i.e. the completing edge.
          mem_we    = PSEL && write_q && !pslverr_q;
          cnt_d     = '0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end
        default: ;
      endcase
    end
  end

  // Word memory; cleared only by reset.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      mem_q <= '{default: '0};
    end else if (mem_we) begin
      mem_q[idx_q] <= PWDATA;
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three completers (0, 3 and 2 wait states) on one
// requester, each with its own PSEL, checked against a word-array model.
module tb_apb_slave_mem;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 64;

  typedef struct {
    int          t;
    bit          wr;
    logic [8:0]  addr;
    logic [31:0] data;
    int          idle;
  } op_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [2:0]    pready;
  logic [2:0]    pslverr;
  logic [DW-1:0] prdata [3];

  int checks_total  = 0;
  int checks_passed = 0;

  logic [31:0] model_mem [3][64];

  always #5 clk = ~clk;

  apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[0]), .PRDATA(prdata[0]),
    .PSLVERR(pslverr[0])
  );

  apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut1 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[1]), .PRDATA(prdata[1]),
    .PSLVERR(pslverr[1])
  );

  apb_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut2 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[2]), .PRDATA(prdata[2]),
    .PSLVERR(pslverr[2])
  );

  function automatic int wait_of(input int t);
    return (t == 0) ? 0 : ((t == 1) ? 3 : 2);
  endfunction

  function automatic op_t mk_op(input int t, input bit wr, input logic [8:0] addr,
                                input logic [31:0] data, input int idle);
    op_t o;
    o.t = t; o.wr = wr; o.addr = addr; o.data = data; o.idle = idle;
    return o;
  endfunction

  function automatic void model_reset();
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < 64; i++) model_mem[t][i] = 32'h0;
  endfunction

  // Reference: byte address -> word index; bad alignment or range is an error.
  function automatic void model_access(input int t, input bit wr, input logic [8:0] addr,
                                       input logic [31:0] wdata, output logic [31:0] exp_rd,
                                       output logic exp_err);
    int idx;
    idx = int'(addr) / 4;
    exp_err = (int'(addr) % 4 != 0) || (idx >= 64);
    exp_rd = 32'h0;
    if (!exp_err) begin
      if (wr) model_mem[t][idx] = wdata;
      else    exp_rd = model_mem[t][idx];
    end
  endfunction

  // One complete transfer; PWDATA is scrambled during wait states.
  task automatic xfer(input int t, input bit wr, input logic [8:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd, output logic err, output int len,
                      output bit stable);
    logic [31:0] first_rd;
    logic        first_err;
    @(negedge clk);
    psel = 3'(1 << t); penable = 1'b0; pwrite = wr; paddr = addr; pwdata = $urandom;
    @(negedge clk);
    penable = 1'b1;
    len = 1;
    first_rd = prdata[t];
    first_err = pslverr[t];
    stable = 1'b1;
    while (pready[t] !== 1'b1 && len < 40) begin
      pwdata = $urandom;
      @(negedge clk);
      len++;
      if (prdata[t] !== first_rd || pslverr[t] !== first_err) stable = 1'b0;
    end
    pwdata = wdata;
    rd = prdata[t];
    err = pslverr[t];
    @(posedge clk);
    #1;
    psel = 3'b000; penable = 1'b0;
  endtask

  task automatic do_op(input op_t op, output logic [31:0] rd, output logic err, output int len,
                       output bit stable, output logic [31:0] exp_rd, output logic exp_err);
    model_access(op.t, op.wr, op.addr, op.data, exp_rd, exp_err);
    xfer(op.t, op.wr, op.addr, op.data, rd, err, len, stable);
    repeat (op.idle) @(negedge clk);
  endtask

  task automatic test_reset();
    op_t ops[$];
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int len;
    bit stable;
    rst_n = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks_total++;
    if ({pready, pslverr, prdata[0], prdata[1], prdata[2]} !== '0)
      $display("FAIL reset_outputs: got ready=%b err=%b rd=%h/%h/%h, want all 0",
               pready, pslverr, prdata[0], prdata[1], prdata[2]);
    else checks_passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks_total++;
    if ({pready, pslverr, prdata[0], prdata[1], prdata[2]} !== '0)
      $display("FAIL reset_idle: got ready=%b err=%b, want 0", pready, pslverr);
    else checks_passed++;
    for (int t = 0; t < 3; t++) ops.push_back(mk_op(t, 1'b0, 9'(4 * $urandom_range(0, 63)), 0, 1));
    foreach (ops[i]) begin
      do_op(ops[i], rd, err, len, stable, exp_rd, exp_err);
      checks_total++;
      if (rd !== exp_rd || err !== exp_err || len != wait_of(ops[i].t) + 1 || !stable)
        $display("FAIL reset_mem[%0d]: got rd=%h err=%b len=%0d stable=%0d, want rd=%h err=%b len=%0d",
                 i, rd, err, len, stable, exp_rd, exp_err, wait_of(ops[i].t) + 1);
      else checks_passed++;
    end
  endtask

  task automatic test_basic();
    op_t ops[$];
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int len;
    bit stable;
    ops.push_back(mk_op(0, 1'b1, 9'h004, 32'hA5A5_0001, 2));
    ops.push_back(mk_op(0, 1'b1, 9'h008, 32'h1234_5678, 3));
    ops.push_back(mk_op(0, 1'b0, 9'h004, 32'h0, 1));
    ops.push_back(mk_op(0, 1'b0, 9'h008, 32'h0, 1));
    foreach (ops[i]) begin
      do_op(ops[i], rd, err, len, stable, exp_rd, exp_err);
      checks_total++;
      if (rd !== exp_rd || err !== exp_err || len != 1 || !stable)
        $display("FAIL basic[%0d]: got rd=%h err=%b len=%0d stable=%0d, want rd=%h err=%b len=1",
                 i, rd, err, len, stable, exp_rd, exp_err);
      else checks_passed++;
    end
  endtask

  task automatic test_wait_states();
    op_t ops[$];
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int len;
    bit stable;
    ops.push_back(mk_op(1, 1'b1, 9'h010, 32'hDEAD_BEEF, 1));
    ops.push_back(mk_op(1, 1'b0, 9'h010, 32'h0, 1));
    ops.push_back(mk_op(2, 1'b1, 9'h010, 32'h0F0F_1234, 0));
    ops.push_back(mk_op(2, 1'b0, 9'h010, 32'h0, 1));
    foreach (ops[i]) begin
      do_op(ops[i], rd, err, len, stable, exp_rd, exp_err);
      checks_total++;
      if (rd !== exp_rd || err !== exp_err || len != wait_of(ops[i].t) + 1 || !stable)
        $display("FAIL wait[%0d]: got rd=%h err=%b len=%0d stable=%0d, want rd=%h err=%b len=%0d",
                 i, rd, err, len, stable, exp_rd, exp_err, wait_of(ops[i].t) + 1);
      else checks_passed++;
    end
  endtask

  task automatic test_errors();
    op_t ops[$];
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int len;
    bit stable;
    ops.push_back(mk_op(0, 1'b1, 9'h100, 32'hFFFF_FFFF, 1));
    ops.push_back(mk_op(0, 1'b1, 9'h005, 32'hFFFF_FFFF, 1));
    ops.push_back(mk_op(0, 1'b0, 9'h100, 32'h0, 1));
    ops.push_back(mk_op(0, 1'b0, 9'h000, 32'h0, 1));
    ops.push_back(mk_op(0, 1'b0, 9'h004, 32'h0, 1));
    ops.push_back(mk_op(1, 1'b0, 9'h1FE, 32'h0, 1));
    foreach (ops[i]) begin
      do_op(ops[i], rd, err, len, stable, exp_rd, exp_err);
      checks_total++;
      if (rd !== exp_rd || err !== exp_err || len != wait_of(ops[i].t) + 1 || !stable)
        $display("FAIL error[%0d]: got rd=%h err=%b len=%0d stable=%0d, want rd=%h err=%b len=%0d",
                 i, rd, err, len, stable, exp_rd, exp_err, wait_of(ops[i].t) + 1);
      else checks_passed++;
    end
  endtask

  task automatic test_back_to_back();
    op_t ops[$];
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int len;
    bit stable;
    ops.push_back(mk_op(0, 1'b1, 9'h00C, 32'h0000_0055, 0));
    ops.push_back(mk_op(0, 1'b0, 9'h00C, 32'h0, 0));
    ops.push_back(mk_op(1, 1'b1, 9'h018, 32'h7777_0001, 0));
    ops.push_back(mk_op(1, 1'b0, 9'h018, 32'h0, 1));
    foreach (ops[i]) begin
      do_op(ops[i], rd, err, len, stable, exp_rd, exp_err);
      checks_total++;
      if (rd !== exp_rd || err !== exp_err || len != wait_of(ops[i].t) + 1 || !stable)
        $display("FAIL b2b[%0d]: got rd=%h err=%b len=%0d stable=%0d, want rd=%h err=%b len=%0d",
                 i, rd, err, len, stable, exp_rd, exp_err, wait_of(ops[i].t) + 1);
      else checks_passed++;
    end
  endtask

  task automatic test_reset_mid_transfer();
    op_t ops[$];
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int len;
    bit stable;
    // Read held in the completing cycle on the zero-wait completer.
    @(negedge clk);
    psel = 3'b001; penable = 1'b0; pwrite = 1'b0; paddr = 9'h00C;
    @(negedge clk);
    penable = 1'b1;
    checks_total++;
    if (pready[0] !== 1'b1 || prdata[0] !== model_mem[0][3])
      $display("FAIL pre_reset_read: got ready=%b rd=%h, want ready=1 rd=%h",
               pready[0], prdata[0], model_mem[0][3]);
    else checks_passed++;
    #2 rst_n = 1'b0;
    #1;
    checks_total++;
    if ({pready[0], pslverr[0], prdata[0]} !== '0)
      $display("FAIL reset_mid_read: got ready=%b err=%b rd=%h, want 0", pready[0], pslverr[0],
               prdata[0]);
    else checks_passed++;
    psel = 3'b000; penable = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    // Write interrupted during a wait state.
    ops.push_back(mk_op(2, 1'b1, 9'h020, 32'h2222_2222, 1));
    foreach (ops[i]) begin
      do_op(ops[i], rd, err, len, stable, exp_rd, exp_err);
      checks_total++;
      if (rd !== exp_rd || err !== exp_err || len != 3 || !stable)
        $display("FAIL pre_write: got rd=%h err=%b len=%0d, want rd=%h err=%b len=3",
                 rd, err, len, exp_rd, exp_err);
      else checks_passed++;
    end
    @(negedge clk);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 9'h020; pwdata = 32'h1111_1111;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks_total++;
    if ({pready, pslverr, prdata[0], prdata[1], prdata[2]} !== '0)
      $display("FAIL reset_mid_write: got ready=%b err=%b rd2=%h, want 0", pready, pslverr,
               prdata[2]);
    else checks_passed++;
    psel = 3'b000; penable = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ops.delete();
    ops.push_back(mk_op(2, 1'b0, 9'h020, 32'h0, 1));
    ops.push_back(mk_op(0, 1'b0, 9'h00C, 32'h0, 1));
    foreach (ops[i]) begin
      do_op(ops[i], rd, err, len, stable, exp_rd, exp_err);
      checks_total++;
      if (rd !== exp_rd || err !== exp_err || len != wait_of(ops[i].t) + 1 || !stable)
        $display("FAIL post_reset[%0d]: got rd=%h err=%b len=%0d, want rd=%h err=%b len=%0d",
                 i, rd, err, len, exp_rd, exp_err, wait_of(ops[i].t) + 1);
      else checks_passed++;
    end
  endtask

  task automatic test_enable_without_setup();
    op_t ops[$];
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int len;
    bit stable;
    @(negedge clk);
    psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 9'h030;
    for (int c = 0; c < 3; c++) begin
      pwdata = $urandom | 32'h1;
      @(negedge clk);
      checks_total++;
      if ({pready[0], pslverr[0], prdata[0]} !== '0)
        $display("FAIL enable_only[%0d]: got ready=%b err=%b rd=%h, want 0", c, pready[0],
                 pslverr[0], prdata[0]);
      else checks_passed++;
    end
    psel = 3'b000; penable = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks_total++;
      if ({pready, pslverr, prdata[0], prdata[1], prdata[2]} !== '0)
        $display("FAIL idle_outputs[%0d]: got ready=%b err=%b, want 0", c, pready, pslverr);
      else checks_passed++;
    end
    ops.push_back(mk_op(0, 1'b0, 9'h030, 32'h0, 1));
    foreach (ops[i]) begin
      do_op(ops[i], rd, err, len, stable, exp_rd, exp_err);
      checks_total++;
      if (rd !== exp_rd || err !== exp_err || len != 1 || !stable)
        $display("FAIL enable_only_mem: got rd=%h err=%b len=%0d, want rd=%h err=%b len=1",
                 rd, err, len, exp_rd, exp_err);
      else checks_passed++;
    end
  endtask

  task automatic test_abort();
    op_t ops[$];
    int n_acc [3] = '{2, 2, 1};
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int len;
    bit stable;
    bit exp_ready;
    ops.push_back(mk_op(1, 1'b1, 9'h040, 32'hCAFE_0001, 1));
    ops.push_back(mk_op(1, 1'b1, 9'h041, 32'hCAFE_0002, 1));
    ops.push_back(mk_op(0, 1'b1, 9'h044, 32'hCAFE_0003, 1));
    foreach (ops[i]) begin
      // Establish the old value.
      do_op(ops[i], rd, err, len, stable, exp_rd, exp_err);
      checks_total++;
      if (rd !== exp_rd || err !== exp_err || len != wait_of(ops[i].t) + 1)
        $display("FAIL abort_pre[%0d]: got rd=%h err=%b len=%0d, want rd=%h err=%b len=%0d",
                 i, rd, err, len, exp_rd, exp_err, wait_of(ops[i].t) + 1);
      else checks_passed++;
      // Start an overwrite and drop PSEL inside the access phase.
      @(negedge clk);
      psel = 3'(1 << ops[i].t); penable = 1'b0; pwrite = 1'b1; paddr = ops[i].addr;
      pwdata = 32'h0BAD_0BAD;
      @(negedge clk);
      penable = 1'b1;
      repeat (n_acc[i] - 1) @(negedge clk);
      exp_ready = (n_acc[i] == wait_of(ops[i].t) + 1);
      checks_total++;
      if (pready[ops[i].t] !== exp_ready || pslverr[ops[i].t] !== exp_err)
        $display("FAIL abort_access[%0d]: got ready=%b err=%b, want ready=%b err=%b", i,
                 pready[ops[i].t], pslverr[ops[i].t], exp_ready, exp_err);
      else checks_passed++;
      psel = 3'b000; penable = 1'b0;
      @(negedge clk);
      checks_total++;
      if ({pready[ops[i].t], pslverr[ops[i].t], prdata[ops[i].t]} !== '0)
        $display("FAIL abort_idle[%0d]: got ready=%b err=%b rd=%h, want 0", i,
                 pready[ops[i].t], pslverr[ops[i].t], prdata[ops[i].t]);
      else checks_passed++;
      do_op(mk_op(ops[i].t, 1'b0, ops[i].addr, 32'h0, 1), rd, err, len, stable, exp_rd, exp_err);
      checks_total++;
      if (rd !== exp_rd || err !== exp_err || len != wait_of(ops[i].t) + 1 || !stable)
        $display("FAIL abort_read[%0d]: got rd=%h err=%b len=%0d, want rd=%h err=%b len=%0d",
                 i, rd, err, len, exp_rd, exp_err, wait_of(ops[i].t) + 1);
      else checks_passed++;
    end
  endtask

  task automatic test_random();
    op_t op;
    logic [31:0] rd, exp_rd;
    logic err, exp_err;
    int len;
    bit stable;
    int kind;
    int idx;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      idx = $urandom_range(0, 15);
      op = mk_op($urandom_range(0, 2), 1'($urandom_range(0, 1)), 9'(idx * 4), $urandom,
                 $urandom_range(0, 2));
      if (kind == 0) op.addr = 9'(idx * 4 + $urandom_range(1, 3));
      if (kind == 1) op.addr = 9'(256 + 4 * $urandom_range(0, 63));
      do_op(op, rd, err, len, stable, exp_rd, exp_err);
      checks_total++;
      if (rd !== exp_rd || err !== exp_err || len != wait_of(op.t) + 1 || !stable)
        $display("FAIL random[%0d] t=%0d wr=%0d a=%h: got rd=%h err=%b len=%0d stable=%0d, want rd=%h err=%b len=%0d",
                 i, op.t, op.wr, op.addr, rd, err, len, stable, exp_rd, exp_err,
                 wait_of(op.t) + 1);
      else checks_passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait_states();
    test_errors();
    test_back_to_back();
    test_reset_mid_transfer();
    test_enable_without_setup();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
